isp_video_timing_gen: RTL and testbench

//   Synthesizable video source driving the ISP per_frame_* / per_img_* interface
//   (vsync, hsync, href, RGB). It generates frame/line timing and test patterns.

---
 rtl/isp_video_timing_gen.sv | 194 +++++++++++++++++++
 tb/tb_isp_video_timing_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_video_timing_gen.sv
// Video timing and test-pattern source for the ISP per_frame_*/per_img_* interface.
// Define VTG_PRBS_PATTERN_EN to make pattern 3 a per-frame reseeded 24-bit LFSR (otherwise pattern 3 = ramp).
module isp_video_timing_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 8,
  parameter int H_BLANK    = 4,
  parameter int V_ACTIVE   = 5,
  parameter int V_BLANK    = 2,
  parameter int HSYNC_W    = 1,
  parameter int VSYNC_W    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [1:0]            pattern_sel_i,
  output logic                  per_frame_vsync_o,
  output logic                  per_frame_hsync_o,
  output logic                  per_frame_href_o,
  output logic [DATA_WIDTH-1:0] per_img_red_o,
  output logic [DATA_WIDTH-1:0] per_img_green_o,
  output logic [DATA_WIDTH-1:0] per_img_blue_o,
  output logic                  frame_done_o
);

  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_BLANK_C = HW'(H_BLANK);
  localparam logic [HW-1:0] HSYNC_C   = HW'(HSYNC_W);
  localparam logic [VW-1:0] V_BLANK_C = VW'(V_BLANK);
  localparam logic [VW-1:0] VSYNC_C   = VW'(VSYNC_W);
  localparam logic [HW-1:0] BAR_DIV   = HW'(H_ACTIVE / 8);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [1:0]            pattern_q, pattern_d;
  logic                  vsync_q, vsync_d;
  logic                  hsync_q, hsync_d;
  logic                  href_q, href_d;
  logic [DATA_WIDTH-1:0] red_q, red_d;
  logic [DATA_WIDTH-1:0] green_q, green_d;
  logic [DATA_WIDTH-1:0] blue_q, blue_d;
  logic                  last_pix_q, last_pix_d;
  logic                  frame_done_q, frame_done_d;

  logic                  active;
  logic                  at_origin;
  logic                  frame_end;
  logic [HW-1:0]         x;
  logic                  y_lsb;
  logic [2:0]            bar;
  logic [DATA_WIDTH-1:0] ramp;

`ifdef VTG_PRBS_PATTERN_EN
  localparam logic [23:0] LFSR_SEED = 24'hACE1E5;
  logic [23:0] lfsr_q, lfsr_d;

  function automatic logic [DATA_WIDTH-1:0] to_dw(input logic [7:0] b);
    logic [DATA_WIDTH+7:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, b};
    return ext[DATA_WIDTH-1:0];
  endfunction
`endif

  always_comb begin
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // A frame that has left the origin always runs to completion, whatever en does.
    active    = en_i || ((state_q != IDLE) && !at_origin);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = (at_origin || frame_end) ? IDLE : STOP;
      STOP:    if (en_i) state_d = RUN;
               else if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (active) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    pattern_d = (active && at_origin) ? pattern_sel_i : pattern_q;

    x     = h_cnt_q - H_BLANK_C;
    y_lsb = v_cnt_q[0] ^ V_BLANK_C[0];
    bar   = 3'(x / BAR_DIV);
    ramp  = DATA_WIDTH'(x);

    hsync_d = active && (h_cnt_q < HSYNC_C);
    vsync_d = active && (v_cnt_q < VSYNC_C);
    href_d  = active && (h_cnt_q >= H_BLANK_C) && (v_cnt_q >= V_BLANK_C);

    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
`ifdef VTG_PRBS_PATTERN_EN
    lfsr_d  = lfsr_q;
    if (active && at_origin) lfsr_d = LFSR_SEED;
`endif
    if (href_d) begin
      case (pattern_q)
        // Bar index bits map to absent channels: bit1 kills R, bit2 kills G, bit0 kills B.
        2'd0: begin
          red_d   = bar[1] ? '0 : ONES;
          green_d = bar[2] ? '0 : ONES;
          blue_d  = bar[0] ? '0 : ONES;
        end
        2'd2: begin
          red_d   = (x[0] ^ y_lsb) ? ONES : '0;
          green_d = red_d;
          blue_d  = red_d;
        end
`ifdef VTG_PRBS_PATTERN_EN
        2'd3: begin
          red_d   = to_dw(lfsr_q[23:16]);
          green_d = to_dw(lfsr_q[15:8]);
          blue_d  = to_dw(lfsr_q[7:0]);
          lfsr_d  = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
        end
`endif
        default: begin
          red_d   = ramp;
          green_d = ramp;
          blue_d  = ramp;
        end
      endcase
    end

    last_pix_d   = active && frame_end;
    frame_done_d = last_pix_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      pattern_q    <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      href_q       <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      last_pix_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      pattern_q    <= pattern_d;
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      href_q       <= href_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      last_pix_q   <= last_pix_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef VTG_PRBS_PATTERN_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`endif

  assign per_frame_vsync_o = vsync_q;
  assign per_frame_hsync_o = hsync_q;
  assign per_frame_href_o  = href_q;
  assign per_img_red_o     = red_q;
  assign per_img_green_o   = green_q;
  assign per_img_blue_o    = blue_q;
  assign frame_done_o      = frame_done_q;

endmodule

// File: tb/tb_isp_video_timing_gen.sv
// Self-checking bench for isp_video_timing_gen: directed steps plus randomized en/pattern
// activity, all compared against a frame-position reference model.
module tb_isp_video_timing_gen;

  localparam int HA = 8, HB = 4, VA = 5, VB = 2, HSW = 1, VSW = 1;
  localparam int HT = HB + HA, VT = VB + VA, FT = HT * VT;
  localparam logic [23:0] SEED = 24'hACE1E5;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       vsync, hsync, href, frameDone;
  logic [7:0] red, green, blue;

  isp_video_timing_gen dut (
    .clk_i(clk), .rst_n_i(rstN), .en_i(en), .pattern_sel_i(sel),
    .per_frame_vsync_o(vsync), .per_frame_hsync_o(hsync), .per_frame_href_o(href),
    .per_img_red_o(red), .per_img_green_o(green), .per_img_blue_o(blue),
    .frame_done_o(frameDone)
  );

  always #5 clk = ~clk;

  int nPass = 0, nChecks = 0, tickNo = 0;

  // Reference model: a frame is a flat sequence of FT positions; it runs while en is high
  // and always finishes once it has left position 0.
  int          mPos = 0;
  int          mPat = 0;
  bit          mLastQ = 1'b0;
  logic [23:0] mLfsr = SEED;
  logic        expVs, expHs, expHref, expFd;
  logic [23:0] expRgb;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s tick=%0d observed=%h expected=%h", tag, tickNo, obs, exp);
  endtask

  function automatic logic [23:0] rampRgb(input int x);
    logic [7:0] v;
    v = 8'(x % 256);
    return {v, v, v};
  endfunction

  task automatic modelPredict();
    int col, line, x, y;
    bit act;
    act = en || (mPos != 0);
    expFd = mLastQ;
    expVs = 0; expHs = 0; expHref = 0; expRgb = '0; mLastQ = 0;
    if (act) begin
      if (mPos == 0) begin
        mPat  = int'(sel);
        mLfsr = SEED;
      end
      col  = mPos % HT;
      line = mPos / HT;
      expHs   = (col < HSW);
      expVs   = (line < VSW);
      expHref = (col >= HB) && (line >= VB);
      if (expHref) begin
        x = col - HB;
        y = line - VB;
        case (mPat)
          0: expRgb = BARS[x * 8 / HA];
          2: expRgb = ((x + y) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
          3: begin
`ifdef VTG_PRBS_PATTERN_EN
            expRgb = mLfsr;
            mLfsr  = {mLfsr[22:0], mLfsr[23] ^ mLfsr[22] ^ mLfsr[21] ^ mLfsr[16]};
`else
            expRgb = rampRgb(x);
`endif
          end
          default: expRgb = rampRgb(x);
        endcase
      end
      mLastQ = (mPos == FT - 1);
      mPos = (mPos + 1) % FT;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".vsync"}, 32'(vsync), 32'(expVs));
    checkVal({tag, ".hsync"}, 32'(hsync), 32'(expHs));
    checkVal({tag, ".href"}, 32'(href), 32'(expHref));
    checkVal({tag, ".rgb"}, 32'({red, green, blue}), 32'(expRgb));
    checkVal({tag, ".frameDone"}, 32'(frameDone), 32'(expFd));
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] s);
    en  = e;
    sel = s;
  endtask

  task automatic stepClock(input string tag);
    modelPredict();
    @(posedge clk);
    #1;
    tickNo++;
    checkOutput(tag);
  endtask

  task automatic zeroExpected();
    expVs = 0; expHs = 0; expHref = 0; expFd = 0; expRgb = '0;
  endtask

  // Holds reset over two edges, checks the cleared outputs, releases just after an edge.
  task automatic doReset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mPos = 0; mPat = 0; mLastQ = 0; mLfsr = SEED;
    zeroExpected();
    checkOutput("reset");
    rstN = 1'b1;
  endtask

  task automatic waitVsyncRise(input string tag);
    bit prev, seen;
    prev = vsync;
    seen = 0;
    for (int i = 0; i < 3 * FT && !seen; i++) begin
      stepClock(tag);
      seen = vsync && !prev;
      prev = vsync;
    end
    checkVal({tag, ".vsyncRiseSeen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int vsCnt, hsCnt, hrefCnt, got;
    int fdTicks[$];
    logic [23:0] pix[$];
    bit seen;

    // Step 1/2: ramp frames from reset, frame-level counts and frame_done spacing.
    applyStimulus(1'b1, 2'd1);
    doReset();
    vsCnt = 0; hsCnt = 0; hrefCnt = 0;
    for (int i = 0; i < 2 * FT + 2; i++) begin
      stepClock("ramp");
      if (i < FT) begin
        vsCnt   += int'(vsync);
        hsCnt   += int'(hsync);
        hrefCnt += int'(href);
      end
      if (frameDone) fdTicks.push_back(tickNo);
    end
    checkVal("vsyncWidth", 32'(vsCnt), 32'(HT * VSW));
    checkVal("hsyncPerFrame", 32'(hsCnt), 32'(VT));
    checkVal("hrefPerFrame", 32'(hrefCnt), 32'(HA * VA));
    checkVal("frameDoneCount", 32'(fdTicks.size()), 32'd2);
    if (fdTicks.size() == 2) begin
      checkVal("frameDoneFirst", 32'(fdTicks[0]), 32'(FT + 1));
      checkVal("frameDonePeriod", 32'(fdTicks[1] - fdTicks[0]), 32'(FT));
    end

    // Step 3: colour bars on the next frame.
    applyStimulus(1'b1, 2'd0);
    waitVsyncRise("barsWait");
    pix.delete();
    for (int i = 0; i < FT && pix.size() < HA; i++) begin
      stepClock("bars");
      if (href) pix.push_back({red, green, blue});
    end
    checkVal("barsCollected", 32'(pix.size()), 32'(HA));
    for (int i = 0; i < pix.size(); i++)
      checkVal($sformatf("bar%0d", i), 32'(pix[i]), 32'(BARS[i]));

    // Step 4: pattern change mid-frame only takes effect at the next frame.
    applyStimulus(1'b1, 2'd1);
    waitVsyncRise("rampWait");
    repeat (30) stepClock("rampHold");
    applyStimulus(1'b1, 2'd2);
    repeat (30) stepClock("rampHold");
    waitVsyncRise("checkerWait");
    pix.delete();
    for (int i = 0; i < FT && pix.size() < 2 * HA; i++) begin
      stepClock("checker");
      if (href) pix.push_back({red, green, blue});
    end
    checkVal("checkerCollected", 32'(pix.size()), 32'(2 * HA));
    for (int i = 0; i < pix.size(); i++)
      checkVal($sformatf("checker%0d", i), 32'(pix[i]),
               ((i % HA + i / HA) % 2 == 1) ? 32'h00FFFFFF : 32'h0);

    // Step 5: en dropped mid-frame -> frame completes, then idle.
    repeat (20) stepClock("preStop");
    applyStimulus(1'b0, 2'd2);
    seen = 0;
    for (int i = 0; i < 2 * FT && !seen; i++) begin
      stepClock("stopping");
      seen = frameDone;
    end
    checkVal("stopFrameDone", 32'(seen), 32'd1);
    repeat (10) stepClock("idle");
    checkVal("idleOutputs", 32'({vsync, hsync, href, frameDone, red, green, blue}), 32'd0);

    // Brief en gap inside a frame resumes with no restart.
    applyStimulus(1'b1, 2'd1);
    repeat (30) stepClock("resume");
    applyStimulus(1'b0, 2'd1);
    repeat (5) stepClock("gap");
    applyStimulus(1'b1, 2'd1);
    repeat (FT) stepClock("resumed");

    // Async reset in the middle of an active line.
    seen = 0;
    for (int i = 0; i < 2 * FT && !seen; i++) begin
      stepClock("findHref");
      seen = href;
    end
    checkVal("hrefBeforeReset", 32'(seen), 32'd1);
    #3;
    rstN = 1'b0;
    #1;
    checkVal("asyncResetOutputs", 32'({vsync, hsync, href, frameDone, red, green, blue}), 32'd0);
    doReset();

    // Step 6: randomized en / pattern activity.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 24) == 0) sel = 2'($urandom_range(0, 3));
      stepClock("random");
    end

    // Step 7: pattern 3 (PRBS when enabled, ramp otherwise), two frames from reset.
    applyStimulus(1'b1, 2'd3);
    doReset();
    seen = 0;
    got = 0;
    for (int i = 0; i < FT && !seen; i++) begin
      stepClock("p3First");
      seen = href;
      got = int'({red, green, blue});
    end
    checkVal("p3HrefSeen", 32'(seen), 32'd1);
`ifdef VTG_PRBS_PATTERN_EN
    checkVal("p3FirstPixel", 32'(got), 32'h00ACE1E5);
`else
    checkVal("p3FirstPixel", 32'(got), 32'h0);
`endif
    repeat (2 * FT) stepClock("p3Frames");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
